ifu_prefetch: RTL and testbench

Sequential instruction prefetch unit sitting directly upstream of the core's `ifetch`/`if_id` front end. It replaces the zero-latency ROM path with a request/grant/response instruction-memory interface. It fetches sequential words into a DEPTH-entry FIFO and presents them to the front end with a valid/ready handshake, tagging each word with its address. A redirect port flushes the buffer and restarts fetch at a new PC, reserved for branch/jump support.

---
 rtl/ifu_prefetch.sv | 93 +++++++++
 tb/tb_ifu_prefetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: issues word fetches on a req/gnt/rvalid memory port,
// buffers address-tagged words in a small FIFO and hands them to the front end.
module ifu_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned DW = $clog2(2 * DEPTH + 1);

    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_addr [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, outstanding;
    logic [DW-1:0] drop;
    logic [31:0]   fetch_pc, resp_pc;

    logic [CW:0]   credits;
    logic [DW:0]   drop_sum, drop_redir;
    logic          xfer, push, pop, rsp_drop, fifo_nonempty;

    // Handshakes: a transfer happens in a cycle where valid and ready (req/gnt,
    // inst_valid/inst_ready) are both high; neither valid is sticky across a redirect.
    assign credits       = {1'b0, count} + {1'b0, outstanding};
    assign mem_req_o     = !rst && !redirect_i && (credits < (CW + 1)'(DEPTH));
    assign mem_addr_o    = fetch_pc;
    assign xfer          = mem_req_o && mem_gnt_i;
    assign rsp_drop      = !redirect_i && mem_rvalid_i && (drop != '0);
    assign push          = !redirect_i && mem_rvalid_i && (drop == '0) && (outstanding != '0);
    assign fifo_nonempty = (count != '0);
    assign inst_valid_o  = !redirect_i && fifo_nonempty;
    assign pop           = inst_valid_o && inst_ready_i;
    assign inst_o        = fifo_nonempty ? fifo_data[rd_ptr] : 32'h0;
    assign inst_addr_o   = fifo_nonempty ? fifo_addr[rd_ptr] : 32'h0;

    // Responses still in flight at a redirect become discards; a response landing
    // in the redirect cycle itself is one of them.
    assign drop_sum   = {1'b0, drop} + (DW + 1)'(outstanding);
    assign drop_redir = (mem_rvalid_i && (drop_sum != '0)) ? drop_sum - (DW + 1)'(1) : drop_sum;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_rdata_i;
            fifo_addr[wr_ptr] <= resp_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect_i) begin
            fetch_pc    <= {redirect_pc_i[31:2], 2'b00};
            resp_pc     <= {redirect_pc_i[31:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= drop_redir[DW-1:0];
        end else begin
            if (xfer) fetch_pc <= fetch_pc + 32'd4;
            if (push) begin
                wr_ptr  <= wr_ptr + PW'(1);
                resp_pc <= resp_pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop) count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
            if (xfer && !push) outstanding <= outstanding + CW'(1);
            else if (!xfer && push) outstanding <= outstanding - CW'(1);
            if (rsp_drop) drop <= drop - DW'(1);
        end
    end
endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: streaming, backpressure, grant stalls, redirects
// and mid-stream reset, against a simple 1-cycle-latency memory model.
module tb_ifu_prefetch;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk, rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        inst_valid_o, inst_ready_i;
    logic [31:0] inst_o, inst_addr_o;

    int compared   = 0;
    int mismatched = 0;
    int xfers      = 0;
    logic auto_mem = 1'b0;

    ifu_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A push into a full FIFO must be impossible under the credit rule.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(int'(dut.count) == 4 && dut.push)) else begin
                mismatched++;
                $display("FAIL full_push: got push with count %0d, want no push", dut.count);
            end
        end
    end

    // One clock; called just after a falling edge. The memory model answers 1 cycle after grant.
    task automatic cycle();
        logic        x;
        logic [31:0] a;
        #1;
        x = mem_req_o && mem_gnt_i;
        a = mem_addr_o;
        if (x) xfers++;
        @(posedge clk);
        @(negedge clk);
        if (auto_mem) begin
            mem_rvalid_i = x && !rst;
            mem_rdata_i  = a ^ K;
        end
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        redirect_i = 1'b0; redirect_pc_i = 32'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        inst_ready_i = 1'b0; auto_mem = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        compared++; if (mem_req_o !== 1'b0) begin mismatched++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
        compared++; if (inst_valid_o !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %b want 0", inst_valid_o); end
        compared++; if (inst_o !== 32'h0) begin mismatched++; $display("FAIL rst_inst: got %h want 0", inst_o); end
        compared++; if (inst_addr_o !== 32'h0) begin mismatched++; $display("FAIL rst_iaddr: got %h want 0", inst_addr_o); end
        compared++; if (mem_addr_o !== 32'h0) begin mismatched++; $display("FAIL rst_maddr: got %h want 0", mem_addr_o); end
        @(negedge clk);
        rst = 1'b0; #1;
        compared++; if (mem_req_o !== 1'b1) begin mismatched++; $display("FAIL first_req: got %b want 1", mem_req_o); end
    endtask

    task automatic test_stream();
        reset_dut();
        inst_ready_i = 1'b1; mem_gnt_i = 1'b1; auto_mem = 1'b1;
        cycle();
        compared++; if (inst_valid_o !== 1'b0) begin mismatched++; $display("FAIL stream_nobypass: got %b want 0", inst_valid_o); end
        cycle();
        for (int k = 0; k < 8; k++) begin
            compared++; if (inst_valid_o !== 1'b1) begin mismatched++; $display("FAIL stream_valid[%0d]: got %b want 1", k, inst_valid_o); end
            compared++; if (inst_addr_o !== 32'(4 * k)) begin mismatched++; $display("FAIL stream_addr[%0d]: got %h want %h", k, inst_addr_o, 32'(4 * k)); end
            compared++; if (inst_o !== (32'(4 * k) ^ K)) begin mismatched++; $display("FAIL stream_data[%0d]: got %h want %h", k, inst_o, 32'(4 * k) ^ K); end
            cycle();
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        inst_ready_i = 1'b0; mem_gnt_i = 1'b1; auto_mem = 1'b1;
        xfers = 0;
        repeat (8) cycle();
        compared++; if (xfers != 4) begin mismatched++; $display("FAIL bp_xfers: got %0d want 4", xfers); end
        compared++; if (mem_req_o !== 1'b0) begin mismatched++; $display("FAIL bp_req: got %b want 0", mem_req_o); end
        compared++; if (inst_addr_o !== 32'h0 || inst_o !== K) begin mismatched++; $display("FAIL bp_head: got %h/%h want 0/%h", inst_addr_o, inst_o, K); end
        inst_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            compared++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'(4 * k)) begin mismatched++; $display("FAIL bp_pop[%0d]: got %b/%h want 1/%h", k, inst_valid_o, inst_addr_o, 32'(4 * k)); end
            if (k == 1) begin
                compared++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10) begin mismatched++; $display("FAIL bp_resume: got %b/%h want 1/00000010", mem_req_o, mem_addr_o); end
            end
            cycle();
        end
    endtask

    task automatic test_gnt_stall();
        reset_dut();
        inst_ready_i = 1'b1; mem_gnt_i = 1'b1; auto_mem = 1'b1;
        cycle(); cycle();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8) begin mismatched++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/00000008", i, mem_req_o, mem_addr_o); end
            cycle();
        end
        mem_gnt_i = 1'b1;
        cycle();
        compared++; if (mem_addr_o !== 32'hC) begin mismatched++; $display("FAIL stall_adv: got %h want 0000000c", mem_addr_o); end
    endtask

    task automatic test_redirect_drop();
        reset_dut();
        inst_ready_i = 1'b0; mem_gnt_i = 1'b1; auto_mem = 1'b0;
        cycle();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0 ^ K; cycle();
        mem_rdata_i = 32'h4 ^ K; cycle();
        mem_rvalid_i = 1'b0; cycle();
        compared++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0) begin mismatched++; $display("FAIL rd_pre: got %b/%h want 1/0", inst_valid_o, inst_addr_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h103; #1;
        compared++; if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin mismatched++; $display("FAIL rd_force: got %b/%b want 0/0", inst_valid_o, mem_req_o); end
        cycle();
        redirect_i = 1'b0; #1;
        compared++; if (inst_valid_o !== 1'b0) begin mismatched++; $display("FAIL rd_empty: got %b want 0", inst_valid_o); end
        compared++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin mismatched++; $display("FAIL rd_newpc: got %b/%h want 1/00000100", mem_req_o, mem_addr_o); end
        cycle();
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h8 ^ K; cycle();
        mem_rdata_i = 32'hC ^ K; cycle();
        compared++; if (inst_valid_o !== 1'b0) begin mismatched++; $display("FAIL rd_discard: got %b want 0", inst_valid_o); end
        mem_rdata_i = 32'h100 ^ K; cycle();
        mem_rvalid_i = 1'b0; #1;
        compared++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h100 || inst_o !== (32'h100 ^ K)) begin
            mismatched++; $display("FAIL rd_head: got %b/%h/%h want 1/00000100/%h", inst_valid_o, inst_addr_o, inst_o, 32'h100 ^ K);
        end
    endtask

    task automatic test_redirect_collide();
        reset_dut();
        inst_ready_i = 1'b0; mem_gnt_i = 1'b1; auto_mem = 1'b0;
        cycle();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0 ^ K; cycle();
        mem_rdata_i = 32'h4 ^ K; cycle();
        mem_rvalid_i = 1'b0; cycle();
        redirect_i = 1'b1; redirect_pc_i = 32'h200; inst_ready_i = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h8 ^ K; #1;
        compared++; if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin mismatched++; $display("FAIL rc_force: got %b/%b want 0/0", inst_valid_o, mem_req_o); end
        cycle();
        redirect_i = 1'b0; mem_rdata_i = 32'hC ^ K; #1;
        compared++; if (inst_valid_o !== 1'b0) begin mismatched++; $display("FAIL rc_nopush: got %b want 0", inst_valid_o); end
        compared++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin mismatched++; $display("FAIL rc_newpc: got %b/%h want 1/00000200", mem_req_o, mem_addr_o); end
        cycle();
        mem_gnt_i = 1'b0; mem_rdata_i = 32'h200 ^ K; #1;
        compared++; if (inst_valid_o !== 1'b0) begin mismatched++; $display("FAIL rc_drop: got %b want 0", inst_valid_o); end
        cycle();
        mem_rvalid_i = 1'b0; #1;
        compared++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h200 || inst_o !== (32'h200 ^ K)) begin
            mismatched++; $display("FAIL rc_head: got %b/%h/%h want 1/00000200/%h", inst_valid_o, inst_addr_o, inst_o, 32'h200 ^ K);
        end
        cycle();
        compared++; if (inst_valid_o !== 1'b0) begin mismatched++; $display("FAIL rc_popped: got %b want 0", inst_valid_o); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        inst_ready_i = 1'b1; mem_gnt_i = 1'b1; auto_mem = 1'b1;
        repeat (4) cycle();
        compared++; if (inst_valid_o !== 1'b1) begin mismatched++; $display("FAIL mid_pre: got %b want 1", inst_valid_o); end
        rst = 1'b1; mem_rvalid_i = 1'b0; #1;
        compared++; if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b0 || inst_addr_o !== 32'h0) begin
            mismatched++; $display("FAIL mid_async: got %b/%b/%h want 0/0/0", inst_valid_o, mem_req_o, inst_addr_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0; #1;
        compared++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin mismatched++; $display("FAIL mid_restart: got %b/%h want 1/0", mem_req_o, mem_addr_o); end
        cycle(); cycle();
        compared++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || inst_o !== K) begin
            mismatched++; $display("FAIL mid_head: got %b/%h/%h want 1/0/%h", inst_valid_o, inst_addr_o, inst_o, K);
        end
    endtask

    initial begin
        rst = 1'b1;
        redirect_i = 1'b0; redirect_pc_i = 32'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        inst_ready_i = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect_drop();
        test_redirect_collide();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
